// File: rtl/i2c_slave_responder.sv
// I2C target: oversamples scl/sda, matches a 7-bit address, then receives or sends NUM_BYTES.
// sda is open-drain: the block only ever pulls it low or releases it.
module i2c_slave_responder #(
    parameter int unsigned           ADDR_LEN   = 7,
    parameter logic [ADDR_LEN-1:0]   SLAVE_ADDR = 7'h2A,
    parameter int unsigned           DATA_LEN   = 8,
    parameter int unsigned           NUM_BYTES  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                scl,
    inout  wire                 sda,
    input  logic [DATA_LEN-1:0] tx_data_1,
    input  logic [DATA_LEN-1:0] tx_data_2,
    output logic [DATA_LEN-1:0] rx_data,
    output logic                rx_valid,
    output logic                rx_index,
    output logic                addr_hit,
    output logic                rw,
    output logic                nack_rx,
    output logic                busy
);
    localparam int unsigned BITW = $clog2(DATA_LEN + 1);
    localparam int unsigned BCW  = $clog2(NUM_BYTES) + 1;
    localparam logic [BITW-1:0] BIT_FULL  = BITW'(DATA_LEN);
    localparam logic [BCW-1:0]  BYTE_FULL = BCW'(NUM_BYTES);

    typedef enum logic [2:0] {
        StIdle, StAddr, StAddrAck, StWrData, StWrAck, StRdData, StRdAck, StIgnore
    } state_t;

    state_t              state;
    logic                scl_s1, scl_s2, scl_d;
    logic                sda_s1, sda_s2, sda_d;
    logic [BITW-1:0]     bit_cnt;
    logic [BCW-1:0]      byte_cnt;
    logic [DATA_LEN-1:0] shreg, tx_shift, tx_buf_1, tx_buf_2;
    logic                sda_oe, ack_seen;

    logic start, stop, rise, fall;
    logic [BCW-1:0]      byte_cnt_inc;
    logic [DATA_LEN-1:0] cur_byte, nxt_byte;

    // Bytes beyond the sourced range read back as all ones (released bus).
    function automatic logic [DATA_LEN-1:0] pick_byte(input logic [BCW-1:0] idx,
                                                      input logic [DATA_LEN-1:0] b1,
                                                      input logic [DATA_LEN-1:0] b2);
        if (idx == '0) return b1;
        if (NUM_BYTES > 1 && idx == BCW'(1)) return b2;
        return '1;
    endfunction

    assign start = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop  = scl_s2 & scl_d & ~sda_d & sda_s2;
    assign rise  = scl_s2 & ~scl_d;
    assign fall  = ~scl_s2 & scl_d;

    assign byte_cnt_inc = (byte_cnt == BYTE_FULL) ? byte_cnt : byte_cnt + BCW'(1);
    assign cur_byte     = pick_byte(byte_cnt, tx_buf_1, tx_buf_2);
    assign nxt_byte     = pick_byte(byte_cnt_inc, tx_buf_1, tx_buf_2);

    assign sda = sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // Synchronisers reset to idle-bus levels so no false edge follows reset.
            scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_d <= 1'b1;
            sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_d <= 1'b1;
            state    <= StIdle;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
            tx_shift <= '0;
            tx_buf_1 <= '0;
            tx_buf_2 <= '0;
            sda_oe   <= 1'b0;
            ack_seen <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_index <= 1'b0;
            addr_hit <= 1'b0;
            rw       <= 1'b0;
            nack_rx  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            scl_s1 <= scl;    scl_s2 <= scl_s1; scl_d <= scl_s2;
            sda_s1 <= sda;    sda_s2 <= sda_s1; sda_d <= sda_s2;
            rx_valid <= 1'b0;
            addr_hit <= 1'b0;
            nack_rx  <= 1'b0;
            if (stop) begin
                state  <= StIdle;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (start) begin
                state   <= StAddr;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    StIdle: sda_oe <= 1'b0;
                    StAddr: begin
                        if (rise && bit_cnt != BIT_FULL) begin
                            shreg   <= {shreg[DATA_LEN-2:0], sda_s2};
                            bit_cnt <= bit_cnt + BITW'(1);
                        end else if (fall && bit_cnt == BIT_FULL) begin
                            if (shreg[DATA_LEN-1 -: ADDR_LEN] == SLAVE_ADDR) begin
                                state    <= StAddrAck;
                                sda_oe   <= 1'b1;
                                addr_hit <= 1'b1;
                                busy     <= 1'b1;
                                rw       <= shreg[0];
                                byte_cnt <= '0;
                                if (shreg[0]) begin
                                    tx_buf_1 <= tx_data_1;
                                    tx_buf_2 <= tx_data_2;
                                end
                            end else begin
                                state  <= StIgnore;
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    StAddrAck: begin
                        if (fall) begin
                            if (rw) begin
                                state    <= StRdData;
                                sda_oe   <= ~cur_byte[DATA_LEN-1];
                                tx_shift <= cur_byte << 1;
                                bit_cnt  <= BITW'(1);
                            end else begin
                                state   <= StWrData;
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                            end
                        end
                    end
                    StWrData: begin
                        if (rise && bit_cnt != BIT_FULL) begin
                            shreg   <= {shreg[DATA_LEN-2:0], sda_s2};
                            bit_cnt <= bit_cnt + BITW'(1);
                        end else if (fall && bit_cnt == BIT_FULL) begin
                            if (byte_cnt < BYTE_FULL) begin
                                state    <= StWrAck;
                                sda_oe   <= 1'b1;
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                                rx_index <= byte_cnt[0];
                                byte_cnt <= byte_cnt_inc;
                            end else begin
                                state  <= StIgnore;
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    StWrAck: begin
                        if (fall) begin
                            state   <= StWrData;
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                        end
                    end
                    StRdData: begin
                        if (fall) begin
                            if (bit_cnt == BIT_FULL) begin
                                state    <= StRdAck;
                                sda_oe   <= 1'b0;
                                ack_seen <= 1'b0;
                            end else begin
                                sda_oe   <= ~tx_shift[DATA_LEN-1];
                                tx_shift <= tx_shift << 1;
                                bit_cnt  <= bit_cnt + BITW'(1);
                            end
                        end
                    end
                    StRdAck: begin
                        if (rise) begin
                            if (sda_s2) begin
                                nack_rx <= 1'b1;
                                state   <= StIgnore;
                            end else begin
                                ack_seen <= 1'b1;
                            end
                        end else if (fall && ack_seen) begin
                            state    <= StRdData;
                            byte_cnt <= byte_cnt_inc;
                            sda_oe   <= ~nxt_byte[DATA_LEN-1];
                            tx_shift <= nxt_byte << 1;
                            bit_cnt  <= BITW'(1);
                        end
                    end
                    StIgnore: sda_oe <= 1'b0;
                    default: begin
                        state  <= StIdle;
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
